// File: rtl/control_unit_if.sv
// Control-unit bus: datapath status and memory/multiplier handshakes in,
// one-hot control word, ALU selector and status flags out.
// master: the control unit; slave: the datapath/memory side.
interface control_unit_if;
   logic        start;
   logic [7:0]  ir_in;
   logic        acc_neg;
   logic        mem_ack;
   logic        mul_done;
   logic [15:0] ctrl;
   logic [3:0]  alu_op;
   logic        halted;
   logic        illegal;

   modport master (
      input  start, ir_in, acc_neg, mem_ack, mul_done,
      output ctrl, alu_op, halted, illegal
   );

   modport slave (
      output start, ir_in, acc_neg, mem_ack, mul_done,
      input  ctrl, alu_op, halted, illegal
   );
endinterface

// File: rtl/control_unit.sv
// Hardwired control unit for the accumulator CPU: fetch, decode and execute
// sequencing with a req/ack memory handshake.
// Optional feature: define CTRL_MPY_EN to decode opcode 0x08 as MPY
// (multi-cycle multiply with the MUL_WAIT state, C10 and alu_op=MUL).
// Without it, 0x08 is an undefined opcode and mul_done is ignored.
module control_unit (
   input logic            clk,
   input logic            rst_n,
   control_unit_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_F_ADDR,
      S_F_MEM,
      S_F_IR,
      S_DECODE,
      S_E_ADDR,
      S_E_MEM,
      S_E_ALU,
      S_HALT
`ifdef CTRL_MPY_EN
      ,S_MUL_WAIT
`endif
   } state_t;

   typedef enum logic [7:0] {
      OP_STORE  = 8'h01,
      OP_LOAD   = 8'h02,
      OP_ADD    = 8'h03,
      OP_SUB    = 8'h04,
      OP_JMPGEZ = 8'h05,
      OP_JMP    = 8'h06,
      OP_HALT   = 8'h07,
      OP_MPY    = 8'h08,
      OP_AND    = 8'h0A,
      OP_OR     = 8'h0B,
      OP_NOT    = 8'h0C,
      OP_SHR    = 8'h0D,
      OP_SHL    = 8'h0E
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_PASS_B = 4'd0,
      ALU_ADD    = 4'd1,
      ALU_SUB    = 4'd2,
      ALU_AND    = 4'd3,
      ALU_OR     = 4'd4,
      ALU_NOT    = 4'd5,
      ALU_SHR    = 4'd6,
      ALU_SHL    = 4'd7,
      ALU_MUL    = 4'd8
   } alu_t;

   // Control bus bit positions
   localparam int unsigned C_PC_INC   = 0;
   localparam int unsigned C_MBR_PC   = 1;
   localparam int unsigned C_PC_MAR   = 2;
   localparam int unsigned C_MBR_MAR  = 3;
   localparam int unsigned C_MBR_IR   = 4;
   localparam int unsigned C_MEM_RD   = 5;
   localparam int unsigned C_ACC_MBR  = 6;
   localparam int unsigned C_MEM_WR   = 7;
   localparam int unsigned C_ALU_ACC  = 9;
   localparam int unsigned C_MUL_GO   = 10;

   state_t      state_q, state_d;
   logic [7:0]  op_q;
   logic [15:0] ctrl_d;
   alu_t        alu_d;
   logic        illegal_d;

`ifndef CTRL_MPY_EN
   logic unused_mul_done;
   assign unused_mul_done = bus.mul_done;
`endif

   // State register and opcode latch; reset aborts any instruction at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            op_q <= bus.ir_in;
      end
   end

   // Next-state decode and combinational control word
   always_comb begin
      state_d   = state_q;
      ctrl_d    = '0;
      alu_d     = ALU_PASS_B;
      illegal_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start)
               state_d = S_F_ADDR;
         end

         S_F_ADDR: begin
            ctrl_d[C_PC_MAR] = 1'b1;
            state_d          = S_F_MEM;
         end

         S_F_MEM: begin
            ctrl_d[C_MEM_RD] = 1'b1;
            if (bus.mem_ack) begin
               ctrl_d[C_PC_INC] = 1'b1;
               state_d          = S_F_IR;
            end
         end

         S_F_IR: begin
            ctrl_d[C_MBR_IR] = 1'b1;
            state_d          = S_DECODE;
         end

         // op_q is not valid yet here, so decode straight from the IR
         S_DECODE: begin
            case (bus.ir_in)
               OP_HALT:
                  state_d = S_HALT;
               OP_JMPGEZ, OP_JMP, OP_NOT, OP_SHR, OP_SHL:
                  state_d = S_E_ALU;
               OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR:
                  state_d = S_E_ADDR;
`ifdef CTRL_MPY_EN
               OP_MPY:
                  state_d = S_E_ADDR;
`endif
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_F_ADDR;
               end
            endcase
         end

         S_E_ADDR: begin
            ctrl_d[C_MBR_MAR] = 1'b1;
            if (op_q == OP_STORE)
               ctrl_d[C_ACC_MBR] = 1'b1;
            state_d = S_E_MEM;
         end

         S_E_MEM: begin
            if (op_q == OP_STORE)
               ctrl_d[C_MEM_WR] = 1'b1;
            else
               ctrl_d[C_MEM_RD] = 1'b1;
            if (bus.mem_ack)
               state_d = (op_q == OP_STORE) ? S_F_ADDR : S_E_ALU;
         end

         S_E_ALU: begin
            state_d = S_F_ADDR;
            case (op_q)
               OP_LOAD: begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_PASS_B; end
               OP_ADD:  begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_ADD;    end
               OP_SUB:  begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_SUB;    end
               OP_AND:  begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_AND;    end
               OP_OR:   begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_OR;     end
               OP_NOT:  begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_NOT;    end
               OP_SHR:  begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_SHR;    end
               OP_SHL:  begin ctrl_d[C_ALU_ACC] = 1'b1; alu_d = ALU_SHL;    end
               OP_JMP:  ctrl_d[C_MBR_PC] = 1'b1;
               OP_JMPGEZ: begin
                  if (!bus.acc_neg)
                     ctrl_d[C_MBR_PC] = 1'b1;
               end
`ifdef CTRL_MPY_EN
               OP_MPY: begin
                  ctrl_d[C_MUL_GO] = 1'b1;
                  state_d          = S_MUL_WAIT;
               end
`endif
               default: ;
            endcase
         end

`ifdef CTRL_MPY_EN
         S_MUL_WAIT: begin
            if (bus.mul_done) begin
               ctrl_d[C_ALU_ACC] = 1'b1;
               alu_d             = ALU_MUL;
               state_d           = S_F_ADDR;
            end
         end
`endif

         S_HALT: state_d = S_HALT;

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.ctrl    = ctrl_d;
   assign bus.alu_op  = alu_d;
   assign bus.illegal = illegal_d;
   assign bus.halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. Each cycle pushes the expected
// outputs to a scoreboard queue and records the DUT outputs mid-cycle; each
// test task then drains both queues and compares. Honors CTRL_MPY_EN.
module tb_control_unit;

   typedef struct packed {
      logic [15:0] ctrl;
      logic [3:0]  alu;
      logic        halted;
      logic        illegal;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t obs_q[$];

   control_unit_if bus();

   control_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [15:0] c, input logic [3:0] a,
                               input logic h, input logic il);
      mk.ctrl = c; mk.alu = a; mk.halted = h; mk.illegal = il;
   endfunction

   // Drive one cycle of inputs, record DUT outputs mid-cycle, push expectation
   task automatic cyc(input logic st, input logic [7:0] ir, input logic neg,
                      input logic ack, input logic md, input exp_t e);
      bus.start    = st;
      bus.ir_in    = ir;
      bus.acc_neg  = neg;
      bus.mem_ack  = ack;
      bus.mul_done = md;
      exp_q.push_back(e);
      #3;
      obs_q.push_back({bus.ctrl, bus.alu_op, bus.halted, bus.illegal});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, o;
      int   k = 0;
      rst_n = 1'b0;
      cyc(1, 8'h0C, 0, 1, 1, mk(16'h0000, 4'd0, 0, 0));
      cyc(1, 8'h09, 0, 1, 1, mk(16'h0000, 4'd0, 0, 0));
      rst_n = 1'b1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL reset[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_not();
      exp_t e, o;
      int   k = 0;
      cyc(1, 8'h0C, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));  // IDLE
      cyc(0, 8'h0C, 0, 0, 0, mk(16'h0004, 4'd0, 0, 0));  // F_ADDR
      cyc(1, 8'h0C, 0, 1, 0, mk(16'h0021, 4'd0, 0, 0));  // F_MEM, start ignored
      cyc(0, 8'h0C, 0, 0, 0, mk(16'h0010, 4'd0, 0, 0));  // F_IR
      cyc(0, 8'h0C, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));  // DECODE
      cyc(0, 8'h0C, 0, 0, 0, mk(16'h0200, 4'd5, 0, 0));  // E_ALU
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL not[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_add_wait();
      exp_t e, o;
      int   k = 0;
      cyc(0, 8'h03, 0, 1, 0, mk(16'h0004, 4'd0, 0, 0));  // F_ADDR, stray ack
      cyc(0, 8'h03, 0, 1, 0, mk(16'h0021, 4'd0, 0, 0));
      cyc(0, 8'h03, 0, 0, 0, mk(16'h0010, 4'd0, 0, 0));
      cyc(0, 8'h03, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));
      cyc(0, 8'h03, 0, 1, 0, mk(16'h0008, 4'd0, 0, 0));  // E_ADDR, stray ack
      cyc(0, 8'h03, 0, 0, 0, mk(16'h0020, 4'd0, 0, 0));  // E_MEM wait
      cyc(0, 8'h03, 0, 0, 0, mk(16'h0020, 4'd0, 0, 0));  // E_MEM wait
      cyc(0, 8'h03, 0, 1, 0, mk(16'h0020, 4'd0, 0, 0));  // E_MEM ack
      cyc(0, 8'h03, 0, 0, 0, mk(16'h0200, 4'd1, 0, 0));  // E_ALU ADD
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL add_wait[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_store();
      exp_t e, o;
      int   k = 0;
      cyc(0, 8'h01, 0, 0, 0, mk(16'h0004, 4'd0, 0, 0));
      cyc(0, 8'h01, 0, 0, 0, mk(16'h0020, 4'd0, 0, 0));  // fetch wait state
      cyc(0, 8'h01, 0, 1, 0, mk(16'h0021, 4'd0, 0, 0));
      cyc(0, 8'h01, 0, 0, 0, mk(16'h0010, 4'd0, 0, 0));
      cyc(0, 8'h01, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));
      cyc(0, 8'h01, 0, 0, 0, mk(16'h0048, 4'd0, 0, 0));  // E_ADDR
      cyc(0, 8'h01, 0, 0, 0, mk(16'h0080, 4'd0, 0, 0));  // write held
      cyc(0, 8'h01, 0, 1, 0, mk(16'h0080, 4'd0, 0, 0));  // write ack
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL store[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_jump();
      exp_t e, o;
      int   k = 0;
      logic [7:0]  op[3]  = '{8'h05, 8'h05, 8'h06};
      logic        neg[3] = '{1'b0, 1'b1, 1'b1};
      logic [15:0] c[3]   = '{16'h0002, 16'h0000, 16'h0002};
      for (int i = 0; i < 3; i++) begin
         cyc(0, op[i], neg[i], 0, 0, mk(16'h0004, 4'd0, 0, 0));
         cyc(0, op[i], neg[i], 1, 0, mk(16'h0021, 4'd0, 0, 0));
         cyc(0, op[i], neg[i], 0, 0, mk(16'h0010, 4'd0, 0, 0));
         cyc(0, op[i], neg[i], 0, 0, mk(16'h0000, 4'd0, 0, 0));
         cyc(0, op[i], neg[i], 0, 0, mk(c[i],     4'd0, 0, 0));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL jump[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_alu_ops();
      exp_t e, o;
      int   k = 0;
      logic [7:0] op[8]  = '{8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
      logic [3:0] alu[8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      for (int i = 0; i < 8; i++) begin
         cyc(0, op[i], 1, 0, 0, mk(16'h0004, 4'd0, 0, 0));
         cyc(0, op[i], 1, 1, 0, mk(16'h0021, 4'd0, 0, 0));
         cyc(0, op[i], 1, 0, 0, mk(16'h0010, 4'd0, 0, 0));
         cyc(0, op[i], 1, 0, 0, mk(16'h0000, 4'd0, 0, 0));
         if (i < 5) begin
            cyc(0, op[i], 1, 0, 0, mk(16'h0008, 4'd0, 0, 0));
            cyc(0, op[i], 1, 1, 0, mk(16'h0020, 4'd0, 0, 0));
         end
         cyc(0, op[i], 1, 0, 0, mk(16'h0200, alu[i], 0, 0));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL alu_ops[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_mpy();
      exp_t e, o;
      int   k = 0;
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0004, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 1, 1, mk(16'h0021, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0010, 4'd0, 0, 0));
`ifdef CTRL_MPY_EN
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0000, 4'd0, 0, 0));  // DECODE
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0008, 4'd0, 0, 0));  // E_ADDR
      cyc(0, 8'h08, 0, 1, 1, mk(16'h0020, 4'd0, 0, 0));  // E_MEM, stray done
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0400, 4'd0, 0, 0));  // C10
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0200, 4'd8, 0, 0));
`else
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0000, 4'd0, 0, 1));  // DECODE: illegal
`endif
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL mpy[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_reset_abort();
      exp_t e, o;
      int   k = 0;
      cyc(0, 8'h02, 0, 0, 0, mk(16'h0004, 4'd0, 0, 0));
      cyc(0, 8'h02, 0, 1, 0, mk(16'h0021, 4'd0, 0, 0));
      cyc(0, 8'h02, 0, 0, 0, mk(16'h0010, 4'd0, 0, 0));
      cyc(0, 8'h02, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));
      cyc(0, 8'h02, 0, 0, 0, mk(16'h0008, 4'd0, 0, 0));
      cyc(0, 8'h02, 0, 0, 0, mk(16'h0020, 4'd0, 0, 0));  // read pending
      rst_n = 1'b0;
      cyc(1, 8'h02, 0, 1, 1, mk(16'h0000, 4'd0, 0, 0));  // request dropped
      rst_n = 1'b1;
      cyc(1, 8'h02, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));  // IDLE
`ifdef CTRL_MPY_EN
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0004, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 1, 0, mk(16'h0021, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0010, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0008, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 1, 0, mk(16'h0020, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0400, 4'd0, 0, 0));
      cyc(0, 8'h08, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));  // MUL_WAIT
      rst_n = 1'b0;
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0000, 4'd0, 0, 0));  // done ignored in reset
      rst_n = 1'b1;
      cyc(0, 8'h08, 0, 0, 1, mk(16'h0000, 4'd0, 0, 0));  // IDLE holds
      cyc(1, 8'h08, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));  // IDLE
`endif
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL reset_abort[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   task automatic test_illegal_halt();
      exp_t e, o;
      int   k = 0;
      cyc(0, 8'h09, 0, 0, 0, mk(16'h0004, 4'd0, 0, 0));
      cyc(0, 8'h09, 0, 1, 0, mk(16'h0021, 4'd0, 0, 0));
      cyc(0, 8'h09, 0, 0, 0, mk(16'h0010, 4'd0, 0, 0));
      cyc(0, 8'h09, 0, 0, 0, mk(16'h0000, 4'd0, 0, 1));  // DECODE illegal
      cyc(0, 8'h09, 0, 0, 0, mk(16'h0004, 4'd0, 0, 0));  // F_ADDR, pulse over
      cyc(0, 8'h07, 0, 1, 0, mk(16'h0021, 4'd0, 0, 0));
      cyc(0, 8'h07, 0, 0, 0, mk(16'h0010, 4'd0, 0, 0));
      cyc(0, 8'h07, 0, 0, 0, mk(16'h0000, 4'd0, 0, 0));  // DECODE HALT
      for (int i = 0; i < 4; i++)
         cyc(1, 8'h0C, 0, 1, 1, mk(16'h0000, 4'd0, 1, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL illegal_halt[%0d]: got ctrl=%h alu=%0d halt=%b ill=%b, want ctrl=%h alu=%0d halt=%b ill=%b",
                     k, o.ctrl, o.alu, o.halted, o.illegal, e.ctrl, e.alu, e.halted, e.illegal);
         end
         k++;
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.ir_in = '0; bus.acc_neg = 1'b0;
      bus.mem_ack = 1'b0; bus.mul_done = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_not();
      test_add_wait();
      test_store();
      test_jump();
      test_alu_ops();
      test_mpy();
      test_reset_abort();
      test_illegal_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control unit for the accumulator CPU datapath. It sequences fetch, decode and execute. It drives the one-hot control bus that loads PC, MAR, MBR, IR and ACC, including C4 (MBR[15:8] → IR), and it decodes the 8-bit opcode that the IR returns. Memory accesses use a request/acknowledge handshake; multiply is an optional multi-cycle operation.

## Interface
Parameters:
- none (the opcode map is fixed; see Operation)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE
- ir_in  in  8  opcode from the IR register
- acc_neg  in  1  ACC[15], sign of the accumulator
- mem_ack  in  1  memory completed the current read or write
- mul_done  in  1  multiplier result valid
- ctrl  out  16  control bus: C0 PC+1, C1 MBR[7:0]→PC, C2 PC→MAR, C3 MBR[7:0]→MAR, C4 MBR[15:8]→IR, C5 MEM_RD, C6 ACC→MBR, C7 MEM_WR, C9 ALU→ACC, C10 MUL_START; C8 and C11–C15 are always 0
- alu_op  out  4  0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, 6 SHR, 7 SHL, 8 MUL; meaningful only while C9=1, otherwise 0
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- Opcodes: 01 STORE, 02 LOAD, 03 ADD, 04 SUB, 05 JMPGEZ, 06 JMP, 07 HALT, 08 MPY, 0A AND, 0B OR, 0C NOT, 0D SHR, 0E SHL. All other values are undefined.
- States:
  - IDLE: ctrl=0.
    - start=1 → F_ADDR.
  - F_ADDR: C2.
    - → F_MEM.
  - F_MEM: C5 held.
    - In the mem_ack=1 cycle, C0 is also asserted → F_IR.
  - F_IR: C4.
    - → DECODE.
  - DECODE: ctrl=0. Registers ir_in into op_q.
    - 07 → HALT.
    - 05, 06, 0C, 0D, 0E → E_ALU.
    - 01, 02, 03, 04, 08, 0A, 0B → E_ADDR.
    - Undefined → illegal pulse in this cycle, then F_ADDR (treated as a NOP).
  - E_ADDR: C3. For STORE, C6 is also asserted.
    - → E_MEM.
  - E_MEM: STORE holds C7; all other opcodes hold C5.
    - mem_ack: STORE → F_ADDR; others → E_ALU.
  - E_ALU:
    - LOAD: C9 with PASS_B.
    - ADD/SUB/AND/OR/NOT/SHR/SHL: C9 with the matching alu_op.
    - JMP: C1.
    - JMPGEZ: C1 only if acc_neg=0.
    - MPY: C10 → MUL_WAIT.
    - All others → F_ADDR.
  - MUL_WAIT: ctrl=0 until mul_done.
    - In the mul_done cycle: C9 with alu_op=MUL → F_ADDR.
  - HALT: halted=1, ctrl=0. Left only by reset.
- ctrl and alu_op are combinational from the state, op_q, mem_ack, mul_done and acc_neg. Consumers sample them at the clk edge.
- start outside IDLE, mem_ack outside F_MEM/E_MEM and mul_done outside MUL_WAIT are ignored.

## Timing
- Reset values: state IDLE, op_q=0, ctrl=0, alu_op=0, halted=0, illegal=0.
- Reset asserted mid-instruction aborts immediately; any memory request is dropped in the same cycle.
- Memory handshake: C5/C7 stay high from state entry through the mem_ack cycle inclusive. mem_ack in the first cycle gives zero wait states.
- Each wait state on mem_ack adds one cycle.
- Zero-wait cycle counts, start of F_ADDR to the next F_ADDR:
  - NOT/SHR/SHL/JMP/JMPGEZ: 5.
  - STORE: 6.
  - LOAD/ADD/SUB/AND/OR: 7.
  - Undefined opcode: 4.
- MPY: 7 cycles plus the number of MUL_WAIT cycles.
- C0 fires exactly once per fetch. C1 in E_ALU overrides that increment on the following edge.

## Configuration
- CTRL_MPY_EN defined: opcode 08 is decoded as MPY; the MUL_WAIT state, C10 and alu_op=MUL exist.
- CTRL_MPY_EN undefined: 08 is undefined (illegal pulse, then F_ADDR); C10 is tied to 0; mul_done is unused.

## Test plan
- Reset, start=1, memory acks immediately, IR returns 0x0C (NOT):
  - C2, C5|C0, C4, 0, C9 with alu_op=5 on consecutive cycles; back in F_ADDR after 5 cycles.
- ADD (0x03) with mem_ack delayed 2 cycles in E_MEM:
  - C5 held for 3 cycles, then C9 with alu_op=1; instruction takes 9 cycles.
- STORE (0x01):
  - ctrl=0x0048 in E_ADDR, then C7 until ack; no C9 at any point.
- JMPGEZ (0x05):
  - acc_neg=0 gives C1=1; acc_neg=1 gives C1=0; both continue to F_ADDR.
- Undefined opcode 0x09:
  - illegal=1 for exactly 1 cycle, next state F_ADDR.
  - 0x07 after that: halted=1 and ctrl=0 held; start ignored.
- MPY (0x08), mul_done after 4 cycles, CTRL_MPY_EN defined:
  - C10 pulse, ctrl=0 for 3 cycles, then C9 with alu_op=8.
  - Without the macro: illegal pulse instead.
  - rst_n low during MUL_WAIT: IDLE with all outputs 0.
